stim_compare_engine: RTL

STIM_COMPARE_ENGINE -- requirements
Module: stim_compare_engine

---
 rtl/stim_cmp_pkg.sv | 25 ++
 rtl/lfsr32.sv | 28 ++
 rtl/stim_compare_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/stim_cmp_pkg.sv
// Shared types and constants for the stimulus/compare engine.
// Holds the FSM state and phase enums plus the LFSR polynomial.
package stim_cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    typedef enum logic {
        PH_DIRECTED,
        PH_RANDOM
    } phase_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Right-shifting Galois step: the feedback bit is the LSB shifted out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load (on rst or load) and step enable.
// Only the low OUT_W bits are exported; the full state still feeds the recurrence.
module lfsr32
    import stim_cmp_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [31:0]      seed,
    output logic [OUT_W-1:0] value
);

    logic [31:0] state_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/stim_compare_engine.sv
// Drives stimulus to a golden model and a netlist, compares their outputs and
// reports mismatch count, first failing vector and pass/fail.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start, outputs from an aborted run retained
// ST_APPLY   | new vector driven on stim (1 cycle)
// ST_SETTLE  | waiting SETTLE_CYCLES for the models to settle
// ST_COMPARE | golden_out vs dut_out sampled and counted (1 cycle)
// ST_DONE    | run finished, done/pass held until next start or rst
module stim_compare_engine
    import stim_cmp_pkg::*;
#(
    parameter int          WIDTH_IN      = 2,
    parameter int          WIDTH_OUT     = 1,
    parameter int          NUM_RANDOM    = 500,
    parameter int          SETTLE_CYCLES = 1,
    parameter int          EXH_MAX       = 8,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] LFSR_SEED     = 32'h1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH_IN-1:0]  stim,
    input  logic [WIDTH_OUT-1:0] golden_out,
    input  logic [WIDTH_OUT-1:0] dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic                 first_fail_valid,
    output logic [WIDTH_IN-1:0]  first_fail_vector
);

    localparam logic [31:0] SEED_EFF    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam bit          DO_DIRECTED = (WIDTH_IN <= EXH_MAX);
    localparam bit          HAS_RANDOM  = (NUM_RANDOM > 0);

    state_t               state;
    phase_t               phase;
    logic [31:0]          settle_cnt;
    logic [31:0]          rnd_left;
    logic [WIDTH_IN-1:0]  lfsr_value;
    logic                 lfsr_en;
    logic                 lfsr_load;
    logic                 mismatch;
    logic [CNT_W-1:0]     cnt_next;
    logic                 go_random_first;
    logic                 end_of_run;

    // The LFSR sits at the seed whenever the engine is idle, so a run always
    // starts from the same sequence; it is reloaded on every exit from a run.
    lfsr32 #(.OUT_W(WIDTH_IN)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .seed  (SEED_EFF),
        .value (lfsr_value)
    );

    assign mismatch        = (golden_out != dut_out);
    assign go_random_first = (phase == PH_DIRECTED) && (&stim) && HAS_RANDOM;
    assign end_of_run      = ((phase == PH_DIRECTED) && (&stim) && !HAS_RANDOM) ||
                             ((phase == PH_RANDOM) && (rnd_left == 32'd0));

    always_comb begin
        cnt_next = mismatch_count;
        if (state == ST_COMPARE && mismatch && mismatch_count != {CNT_W{1'b1}}) begin
            cnt_next = mismatch_count + CNT_W'(1);
        end
    end

    always_comb begin
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !abort && !DO_DIRECTED && HAS_RANDOM) lfsr_en = 1'b1;
            end
            ST_APPLY, ST_SETTLE: begin
                if (abort) lfsr_load = 1'b1;
            end
            ST_COMPARE: begin
                if (abort || end_of_run) begin
                    lfsr_load = 1'b1;
                end else if (phase == PH_RANDOM || go_random_first) begin
                    lfsr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            phase             <= PH_DIRECTED;
            stim              <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            mismatch_count    <= '0;
            first_fail_valid  <= 1'b0;
            first_fail_vector <= '0;
            settle_cnt        <= '0;
            rnd_left          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        mismatch_count    <= '0;
                        first_fail_valid  <= 1'b0;
                        first_fail_vector <= '0;
                        pass              <= 1'b0;
                        if (DO_DIRECTED) begin
                            phase <= PH_DIRECTED;
                            stim  <= '0;
                            state <= ST_APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else if (HAS_RANDOM) begin
                            phase    <= PH_RANDOM;
                            stim     <= lfsr_value;
                            rnd_left <= 32'(NUM_RANDOM - 1);
                            state    <= ST_APPLY;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (SETTLE_CYCLES > 0) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 32'(SETTLE_CYCLES - 1);
                    end else begin
                        state <= ST_COMPARE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (settle_cnt == 32'd0) begin
                        state <= ST_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 32'd1;
                    end
                end
                ST_COMPARE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        mismatch_count <= cnt_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid  <= 1'b1;
                            first_fail_vector <= stim;
                        end
                        if (end_of_run) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (cnt_next == '0);
                        end else begin
                            state <= ST_APPLY;
                            if (go_random_first) begin
                                phase    <= PH_RANDOM;
                                stim     <= lfsr_value;
                                rnd_left <= 32'(NUM_RANDOM - 1);
                            end else if (phase == PH_RANDOM) begin
                                stim     <= lfsr_value;
                                rnd_left <= rnd_left - 32'd1;
                            end else begin
                                stim <= stim + WIDTH_IN'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
